// File: rtl/rob_commit_seq_if.sv
// Issue, rename, CDB and commit signals shared between the issue stage, the
// reorder buffer and the register file.
interface rob_commit_seq_if #(
    parameter int Q_WIDTH        = 4,
    parameter int REG_ADDR_WIDTH = 5
);
    logic                      issue_valid;
    logic [REG_ADDR_WIDTH-1:0] issue_rd;
    logic                      issue_ready;
    logic [Q_WIDTH-1:0]        issue_tag;
    logic                      rd_control;
    logic [REG_ADDR_WIDTH-1:0] rd;
    logic [Q_WIDTH-1:0]        Q_value;
    logic                      wb_valid;
    logic [Q_WIDTH-1:0]        wb_tag;
    logic [31:0]               wb_value;
    logic                      has_commit;
    logic [REG_ADDR_WIDTH-1:0] commit_target;
    logic [Q_WIDTH-1:0]        Commit_Q;
    logic [31:0]               Commit_V;
    logic [Q_WIDTH-1:0]        rob_count;

    modport master (
        output issue_valid, issue_rd, wb_valid, wb_tag, wb_value,
        input  issue_ready, issue_tag, rd_control, rd, Q_value,
               has_commit, commit_target, Commit_Q, Commit_V, rob_count
    );

    modport slave (
        input  issue_valid, issue_rd, wb_valid, wb_tag, wb_value,
        output issue_ready, issue_tag, rd_control, rd, Q_value,
               has_commit, commit_target, Commit_Q, Commit_V, rob_count
    );
endinterface

// File: rtl/rob_commit_seq.sv
// In-order commit sequencer: allocates rename tags 1..DEPTH at issue, marks
// entries ready from the CDB and retires them in program order.
module rob_commit_seq #(
    parameter int Q_WIDTH        = 4,
    parameter int REG_ADDR_WIDTH = 5
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              rdy_in,
    input  logic              flush_in,
    rob_commit_seq_if.slave   bus
);
    localparam int                 ENTRIES   = 2**Q_WIDTH;
    localparam logic [Q_WIDTH-1:0] DEPTH     = Q_WIDTH'(ENTRIES - 1);
    localparam logic [Q_WIDTH-1:0] FIRST_TAG = Q_WIDTH'(1);

    logic [ENTRIES-1:0]        busy_q, busy_d, ready_q, ready_d;
    logic [REG_ADDR_WIDTH-1:0] rd_q    [ENTRIES];
    logic [REG_ADDR_WIDTH-1:0] rd_d    [ENTRIES];
    logic [31:0]               value_q [ENTRIES];
    logic [31:0]               value_d [ENTRIES];
    logic [Q_WIDTH-1:0]        head_q, head_d, tail_q, tail_d, count_q, count_d;
    logic                      has_commit_q, has_commit_d;
    logic [REG_ADDR_WIDTH-1:0] commit_target_q, commit_target_d;
    logic [Q_WIDTH-1:0]        commit_tag_q, commit_tag_d;
    logic [31:0]               commit_value_q, commit_value_d;
    logic                      issue_ok, commit_ok, wb_ok;

    // Tag 0 is reserved for "no producer", so pointers wrap DEPTH -> 1.
    function automatic logic [Q_WIDTH-1:0] next_tag(input logic [Q_WIDTH-1:0] t);
        return (t == DEPTH) ? FIRST_TAG : t + FIRST_TAG;
    endfunction

    always_comb begin
        issue_ok  = bus.issue_valid && (count_q != DEPTH) && rdy_in && !flush_in;
        commit_ok = busy_q[head_q] && ready_q[head_q];
        wb_ok     = bus.wb_valid && busy_q[bus.wb_tag];

        busy_d          = busy_q;
        ready_d         = ready_q;
        rd_d            = rd_q;
        value_d         = value_q;
        head_d          = head_q;
        tail_d          = tail_q;
        count_d         = count_q;
        has_commit_d    = has_commit_q;
        commit_target_d = commit_target_q;
        commit_tag_d    = commit_tag_q;
        commit_value_d  = commit_value_q;

        if (rdy_in) begin
            if (flush_in) begin
                busy_d       = '0;
                ready_d      = '0;
                head_d       = FIRST_TAG;
                tail_d       = FIRST_TAG;
                count_d      = '0;
                has_commit_d = 1'b0;
            end else begin
                has_commit_d = commit_ok;
                if (wb_ok) begin
                    ready_d[bus.wb_tag] = 1'b1;
                    value_d[bus.wb_tag] = bus.wb_value;
                end
                // Commit reads pre-edge state, so a same-cycle writeback never bypasses.
                if (commit_ok) begin
                    commit_target_d = rd_q[head_q];
                    commit_tag_d    = head_q;
                    commit_value_d  = value_q[head_q];
                    busy_d[head_q]  = 1'b0;
                    head_d          = next_tag(head_q);
                end
                if (issue_ok) begin
                    busy_d[tail_q]  = 1'b1;
                    ready_d[tail_q] = 1'b0;
                    rd_d[tail_q]    = bus.issue_rd;
                    tail_d          = next_tag(tail_q);
                end
                count_d = count_q + Q_WIDTH'(issue_ok) - Q_WIDTH'(commit_ok);
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            busy_q          <= '0;
            ready_q         <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                rd_q[i]    <= '0;
                value_q[i] <= '0;
            end
            head_q          <= FIRST_TAG;
            tail_q          <= FIRST_TAG;
            count_q         <= '0;
            has_commit_q    <= 1'b0;
            commit_target_q <= '0;
            commit_tag_q    <= '0;
            commit_value_q  <= '0;
        end else begin
            busy_q          <= busy_d;
            ready_q         <= ready_d;
            rd_q            <= rd_d;
            value_q         <= value_d;
            head_q          <= head_d;
            tail_q          <= tail_d;
            count_q         <= count_d;
            has_commit_q    <= has_commit_d;
            commit_target_q <= commit_target_d;
            commit_tag_q    <= commit_tag_d;
            commit_value_q  <= commit_value_d;
        end
    end

    assign bus.issue_ready   = (count_q != DEPTH);
    assign bus.issue_tag     = tail_q;
    assign bus.rd_control    = issue_ok;
    assign bus.rd            = bus.issue_rd;
    assign bus.Q_value       = tail_q;
    assign bus.has_commit    = has_commit_q;
    assign bus.commit_target = commit_target_q;
    assign bus.Commit_Q      = commit_tag_q;
    assign bus.Commit_V      = commit_value_q;
    assign bus.rob_count     = count_q;
endmodule

// File: tb/tb_rob_commit_seq.sv
// Directed bench for rob_commit_seq: ordering, full buffer, flush, stall and
// stale-writeback scenarios with hand-computed expectations.
module tb_rob_commit_seq;
    logic clk_in;
    logic rst_in;
    logic rdy_in;
    logic flush_in;
    int   checks;
    int   errors;

    rob_commit_seq_if #(.Q_WIDTH(4), .REG_ADDR_WIDTH(5)) bus ();

    rob_commit_seq #(.Q_WIDTH(4), .REG_ADDR_WIDTH(5)) dut (
        .clk_in   (clk_in),
        .rst_in   (rst_in),
        .rdy_in   (rdy_in),
        .flush_in (flush_in),
        .bus      (bus)
    );

    initial begin
        clk_in = 1'b0;
        forever #5 clk_in = ~clk_in;
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, actual, expected, $time);
        end
    endtask

    // Inputs change 1ns after the rising edge and settle before sampling.
    task automatic applyStimulus(input logic iv, input logic [4:0] ird, input logic wv,
                                 input logic [3:0] wtag, input logic [31:0] wval,
                                 input logic fl, input logic rdy);
        bus.issue_valid = iv;
        bus.issue_rd    = ird;
        bus.wb_valid    = wv;
        bus.wb_tag      = wtag;
        bus.wb_value    = wval;
        flush_in        = fl;
        rdy_in          = rdy;
        #1;
    endtask

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic idle();
        applyStimulus(1'b0, 5'd0, 1'b0, 4'd0, 32'd0, 1'b0, 1'b1);
    endtask

    task automatic doReset();
        rst_in = 1'b0;
        idle();
        tick();
        tick();
        rst_in = 1'b1;
    endtask

    task automatic checkCommit(input string tag, input logic hc, input logic [3:0] q,
                               input logic [31:0] v, input logic [4:0] tgt);
        checkOutput({tag, "_has_commit"}, 32'(bus.has_commit), 32'(hc));
        checkOutput({tag, "_Commit_Q"}, 32'(bus.Commit_Q), 32'(q));
        checkOutput({tag, "_Commit_V"}, bus.Commit_V, v);
        checkOutput({tag, "_commit_target"}, 32'(bus.commit_target), 32'(tgt));
    endtask

    initial begin
        checks = 0;
        errors = 0;
        doReset();
        checkCommit("reset", 1'b0, 4'd0, 32'd0, 5'd0);
        checkOutput("reset_count", 32'(bus.rob_count), 0);
        checkOutput("reset_issue_tag", 32'(bus.issue_tag), 1);
        checkOutput("reset_issue_ready", 32'(bus.issue_ready), 1);

        // In-order commit despite out-of-order writeback.
        applyStimulus(1'b1, 5'd5, 1'b0, 4'd0, 32'd0, 1'b0, 1'b1);
        checkOutput("t1_rd_control", 32'(bus.rd_control), 1);
        checkOutput("t1_Q_value", 32'(bus.Q_value), 1);
        checkOutput("t1_rd", 32'(bus.rd), 5);
        tick();
        applyStimulus(1'b1, 5'd6, 1'b0, 4'd0, 32'd0, 1'b0, 1'b1);
        checkOutput("t1_issue_tag2", 32'(bus.issue_tag), 2);
        tick();
        applyStimulus(1'b0, 5'd0, 1'b1, 4'd2, 32'hBB, 1'b0, 1'b1);
        tick();
        applyStimulus(1'b0, 5'd0, 1'b1, 4'd1, 32'hAA, 1'b0, 1'b1);
        tick();
        checkOutput("t1_no_bypass", 32'(bus.has_commit), 0);
        idle();
        tick();
        checkCommit("t1_c1", 1'b1, 4'd1, 32'hAA, 5'd5);
        tick();
        checkCommit("t1_c2", 1'b1, 4'd2, 32'hBB, 5'd6);
        checkOutput("t1_count", 32'(bus.rob_count), 0);
        tick();
        checkCommit("t1_idle", 1'b0, 4'd2, 32'hBB, 5'd6);

        // Fill all 15 entries, then exercise the full boundary and tag wrap.
        doReset();
        for (int i = 1; i <= 15; i++) begin
            applyStimulus(1'b1, 5'(i), 1'b0, 4'd0, 32'd0, 1'b0, 1'b1);
            checkOutput("fill_tag", 32'(bus.issue_tag), 32'(i));
            tick();
        end
        checkOutput("full_count", 32'(bus.rob_count), 15);
        checkOutput("full_issue_ready", 32'(bus.issue_ready), 0);
        applyStimulus(1'b1, 5'd20, 1'b1, 4'd1, 32'h11, 1'b0, 1'b1);
        checkOutput("full_reject16", 32'(bus.rd_control), 0);
        tick();
        checkOutput("full_count_hold", 32'(bus.rob_count), 15);
        applyStimulus(1'b1, 5'd20, 1'b0, 4'd0, 32'd0, 1'b0, 1'b1);
        checkOutput("full_same_edge_reject", 32'(bus.rd_control), 0);
        tick();
        checkCommit("full_c1", 1'b1, 4'd1, 32'h11, 5'd1);
        checkOutput("full_count14", 32'(bus.rob_count), 14);
        applyStimulus(1'b1, 5'd21, 1'b1, 4'd2, 32'h12, 1'b0, 1'b1);
        checkOutput("wrap_accept", 32'(bus.rd_control), 1);
        checkOutput("wrap_tag", 32'(bus.issue_tag), 1);
        tick();
        checkOutput("refill_count", 32'(bus.rob_count), 15);
        applyStimulus(1'b1, 5'd22, 1'b0, 4'd0, 32'd0, 1'b0, 1'b1);
        checkOutput("refull_reject", 32'(bus.rd_control), 0);
        tick();
        checkCommit("full_c2", 1'b1, 4'd2, 32'h12, 5'd2);

        // Flush with four in flight and two ready.
        doReset();
        applyStimulus(1'b1, 5'd1, 1'b0, 4'd0, 32'd0, 1'b0, 1'b1);
        tick();
        applyStimulus(1'b1, 5'd2, 1'b0, 4'd0, 32'd0, 1'b0, 1'b1);
        tick();
        applyStimulus(1'b1, 5'd3, 1'b1, 4'd2, 32'h22, 1'b0, 1'b1);
        tick();
        applyStimulus(1'b1, 5'd4, 1'b1, 4'd1, 32'h21, 1'b0, 1'b1);
        tick();
        checkOutput("pre_flush_count", 32'(bus.rob_count), 4);
        applyStimulus(1'b1, 5'd5, 1'b0, 4'd0, 32'd0, 1'b1, 1'b1);
        checkOutput("flush_rd_control", 32'(bus.rd_control), 0);
        tick();
        checkOutput("flush_has_commit", 32'(bus.has_commit), 0);
        checkOutput("flush_count", 32'(bus.rob_count), 0);
        checkOutput("flush_issue_tag", 32'(bus.issue_tag), 1);
        applyStimulus(1'b0, 5'd0, 1'b1, 4'd2, 32'h99, 1'b0, 1'b1);
        tick();
        applyStimulus(1'b1, 5'd7, 1'b0, 4'd0, 32'd0, 1'b0, 1'b1);
        tick();
        applyStimulus(1'b1, 5'd8, 1'b0, 4'd0, 32'd0, 1'b0, 1'b1);
        tick();
        idle();
        tick();
        tick();
        checkOutput("post_flush_no_commit", 32'(bus.has_commit), 0);
        checkOutput("post_flush_count", 32'(bus.rob_count), 2);
        applyStimulus(1'b0, 5'd0, 1'b1, 4'd1, 32'h71, 1'b0, 1'b1);
        tick();
        applyStimulus(1'b1, 5'd9, 1'b0, 4'd0, 32'd0, 1'b0, 1'b1);
        checkOutput("same_edge_issue", 32'(bus.rd_control), 1);
        checkOutput("same_edge_tag", 32'(bus.issue_tag), 3);
        tick();
        checkCommit("flush_c1", 1'b1, 4'd1, 32'h71, 5'd7);
        checkOutput("same_edge_count", 32'(bus.rob_count), 2);

        // Stall with the head ready: nothing moves until rdy_in returns.
        applyStimulus(1'b0, 5'd0, 1'b1, 4'd2, 32'h22, 1'b0, 1'b1);
        tick();
        checkOutput("pre_stall_has_commit", 32'(bus.has_commit), 0);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 5'd10, 1'b0, 4'd0, 32'd0, 1'b0, 1'b0);
            checkOutput("stall_rd_control", 32'(bus.rd_control), 0);
            tick();
            checkCommit("stall", 1'b0, 4'd1, 32'h71, 5'd7);
            checkOutput("stall_count", 32'(bus.rob_count), 2);
            checkOutput("stall_issue_tag", 32'(bus.issue_tag), 4);
        end
        idle();
        tick();
        checkCommit("resume_c", 1'b1, 4'd2, 32'h22, 5'd8);
        tick();
        checkCommit("resume_once", 1'b0, 4'd2, 32'h22, 5'd8);
        checkOutput("resume_count", 32'(bus.rob_count), 1);

        // Stale writeback to tag 9 before it is allocated must not count.
        applyStimulus(1'b0, 5'd0, 1'b1, 4'd9, 32'hDEAD, 1'b0, 1'b1);
        tick();
        for (int t = 4; t <= 9; t++) begin
            applyStimulus(1'b1, 5'(t + 10), 1'b0, 4'd0, 32'd0, 1'b0, 1'b1);
            checkOutput("stale_issue_tag", 32'(bus.issue_tag), 32'(t));
            tick();
        end
        checkOutput("stale_count", 32'(bus.rob_count), 7);
        for (int t = 3; t <= 8; t++) begin
            applyStimulus(1'b0, 5'd0, 1'b1, 4'(t), 32'h100 + 32'(t), 1'b0, 1'b1);
            tick();
            if (t >= 4) begin
                checkOutput("drain_has_commit", 32'(bus.has_commit), 1);
                checkOutput("drain_Commit_Q", 32'(bus.Commit_Q), 32'(t - 1));
            end
        end
        idle();
        tick();
        checkCommit("drain_c8", 1'b1, 4'd8, 32'h108, 5'd18);
        tick();
        checkOutput("stale_not_ready", 32'(bus.has_commit), 0);
        tick();
        checkOutput("stale_still_waiting", 32'(bus.has_commit), 0);
        checkOutput("stale_wait_count", 32'(bus.rob_count), 1);
        applyStimulus(1'b0, 5'd0, 1'b1, 4'd9, 32'h99, 1'b0, 1'b1);
        tick();
        idle();
        tick();
        checkCommit("fresh_c9", 1'b1, 4'd9, 32'h99, 5'd19);
        checkOutput("final_count", 32'(bus.rob_count), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/rob_commit_seq.md
# rob_commit_seq

In-order commit sequencer and rename-tag allocator for the register file. It holds a circular buffer of in-flight register-writing instructions. It hands out rename tags at issue, drives the register file's rename port, and marks entries ready from the common data bus. Completed results retire in program order onto the register file's commit port. It sits between the issue stage, the CDB and the register file.

## Interface
- `Q_WIDTH`, default 4: tag width. Tag 0 means "no pending producer" and is never allocated. Depth is `DEPTH = 2**Q_WIDTH-1` (15).
- `REG_ADDR_WIDTH`, default 5: architectural register address width.

Ports:
- `clk_in`  in  1  system clock; the only clock in the block.
- `rst_in`  in  1  reset; synchronous, active-low.
- `rdy_in`  in  1  global enable. While low, all state is frozen and registered outputs hold.
- `issue_valid`  in  1  issue stage requests an entry.
- `issue_rd`  in  REG_ADDR_WIDTH  destination register of the issuing instruction.
- `issue_ready`  out  1  an entry is free (`count != DEPTH`); combinational.
- `issue_tag`  out  Q_WIDTH  tag that the next accepted issue receives (the tail pointer).
- `rd_control`  out  1  equals `issue_valid & issue_ready & rdy_in`; drives the regfile rename write.
- `rd`  out  REG_ADDR_WIDTH  equals `issue_rd`.
- `Q_value`  out  Q_WIDTH  equals `issue_tag`.
- `wb_valid`  in  1  CDB broadcast valid.
- `wb_tag`  in  Q_WIDTH  producing tag.
- `wb_value`  in  32  result.
- `flush_in`  in  1  mispredict flush. The top level flushes regfile Q state in the same cycle.
- `has_commit`  out  1  registered, one-cycle commit pulse.
- `commit_target`  out  REG_ADDR_WIDTH  registered; rd of the retiring entry.
- `Commit_Q`  out  Q_WIDTH  registered; tag of the retiring entry.
- `Commit_V`  out  32  registered; value of the retiring entry.
- `rob_count`  out  Q_WIDTH  number of occupied entries.

## Operation
- Per-entry storage: `busy`, `ready`, `rd[REG_ADDR_WIDTH]`, `value[32]`. Entries are indexed by tag 1..DEPTH.
- Pointers `head` and `tail` are Q_WIDTH bits and are reset to 1. Increment wraps DEPTH→1, skipping 0.
- Accepted issue (`rd_control`=1) does the following:
  - sets the tail entry to busy=1, ready=0, rd=issue_rd;
  - advances `tail`;
  - increments `count`.
- An issue with `issue_rd`=0 is still allocated. It commits with `commit_target`=0, which the regfile ignores.
- Writeback: when `wb_valid` and `busy[wb_tag]`, the block sets `ready[wb_tag]`=1 and `value[wb_tag]`=wb_value.
  - A writeback to a non-busy tag or to tag 0 is ignored.
  - A repeat writeback to an already-ready entry overwrites its value.
- Commit: at most one per cycle. When `busy[head] & ready[head]` at the edge:
  - register `has_commit`=1, `commit_target`=rd[head], `Commit_Q`=head and `Commit_V`=value[head];
  - clear busy[head];
  - advance `head`;
  - decrement `count`.
- If the head entry is not ready, `has_commit` is 0 on the next cycle and the other commit outputs hold their last values.
- Same-edge issue and commit: both take effect, so `count` is unchanged.
  - `issue_ready` is computed from the pre-edge count, so there is no same-cycle slot reuse when full.
- Writeback to the head entry takes effect at edge N. That entry commits at edge N+1. There is no CDB-to-commit bypass.
- Flush (`flush_in`=1 with `rdy_in`=1) has priority over issue, writeback and commit in the same cycle:
  - clears all busy and ready bits;
  - sets head=tail=1 and count=0;
  - forces `has_commit`=0 on the next cycle;
  - suppresses `rd_control` combinationally.
- Reset (`rst_in`=0 at an edge) has highest priority, including over `rdy_in`=0. Every output is reset:
  - registered outputs: `has_commit`=0, `commit_target`=0, `Commit_Q`=0, `Commit_V`=0;
  - `rob_count`=0;
  - `issue_tag`=1;
  - `issue_ready`=1.
- Reset mid-operation discards all in-flight entries.

## Timing
- Issue to tag visible: the tag is on `issue_tag` in the same cycle and is captured by the regfile at the same edge.
- Issue to earliest commit: writeback on the issue cycle is ignored because the entry is not yet busy.
  - Writeback at the edge after issue (N+1) makes the entry ready.
  - Commit is registered at N+2, so `has_commit` is high in the cycle after N+2.
- Throughput: one issue and one commit per cycle, sustained.
- `rdy_in`=0 freezes pointers, entries and registered outputs. A held `has_commit`=1 is harmless because the regfile is also stalled.

## Test plan
- Reset, then issue rd=5 and rd=6 (tags 1 and 2). Writeback tag 2=0xBB, then tag 1=0xAA. Required: commits occur in order, tag 1 (0xAA, rd 5) then tag 2 (0xBB, rd 6), on consecutive cycles.
- Issue 15 back-to-back. Required: `issue_ready`=0 with count=15. A 16th `issue_valid` produces no `rd_control`. After one commit the tail has wrapped, so the next tag issued is 1, not 0.
- Keep the buffer full and commit the head on the same edge as `issue_valid`. Required: the issue is rejected that cycle and accepted the following cycle; count stays 15.
- With 4 entries in flight, tags 1–2 ready, assert `flush_in`. Required: no `has_commit` next cycle, count=0, `issue_tag`=1. A later writeback to tag 2 is ignored.
- Drop `rdy_in` for 3 cycles while the head is ready. Required: no head advance and outputs held. On resume exactly one commit of that entry occurs.
- Writeback to tag 9 while it is not busy, then issue up to tag 9. Required: entry 9 is not ready, and no commit occurs until a fresh writeback.
